// File: rtl/tlc_car_sensor.sv
// Country-road car sensor for the traffic light controller: synchronises and
// debounces the loop detector, queues vehicles and drains them on green.
module tlc_car_sensor #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned SERVE_CYCLES = 3,
    parameter int unsigned CNT_W        = 4,
    parameter logic [1:0]  GREEN        = 2'b10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             raw_det,
    input  logic [1:0]       ctrd,
    output logic             x,
    output logic [CNT_W-1:0] car_cnt,
    output logic [1:0]       sts,
    output logic             overflow
);

    typedef enum logic [1:0] {
        STS_IDLE    = 2'b00,
        STS_QUEUED  = 2'b01,
        STS_SERVING = 2'b10
    } sts_e;

    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             s1_q, s2_q;
    logic             det_stable_q, det_stable_d;
    logic             det_prev_q;
    logic             arrival_q, arrival_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [SRV_W-1:0] srv_cnt_q, srv_cnt_d;
    logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
    logic             overflow_q, overflow_d;
    logic             serve_en;
    logic             departure;
    sts_e             sts_w;

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        det_stable_d = det_stable_q;
        deb_cnt_d    = '0;
        if (s2_q != det_stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                det_stable_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // An arrival is the registered rising edge of the debounced level; falls are ignored.
    assign arrival_d = det_stable_q & ~det_prev_q;

    assign serve_en  = (ctrd == GREEN) && (car_cnt_q != '0);
    assign departure = serve_en && (srv_cnt_q == SRV_LAST);

    always_comb begin
        srv_cnt_d = '0;
        if (serve_en && !departure) begin
            srv_cnt_d = srv_cnt_q + SRV_W'(1);
        end
    end

    always_comb begin
        car_cnt_d  = car_cnt_q;
        overflow_d = overflow_q;
        case ({arrival_q, departure})
            2'b10: begin
                if (car_cnt_q == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    car_cnt_d = car_cnt_q + CNT_W'(1);
                end
            end
            2'b01:   car_cnt_d = car_cnt_q - CNT_W'(1);
            default: car_cnt_d = car_cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            det_stable_q <= 1'b0;
            det_prev_q   <= 1'b0;
            arrival_q    <= 1'b0;
            deb_cnt_q    <= '0;
            srv_cnt_q    <= '0;
            car_cnt_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            s1_q         <= raw_det;
            s2_q         <= s1_q;
            det_stable_q <= det_stable_d;
            det_prev_q   <= det_stable_q;
            arrival_q    <= arrival_d;
            deb_cnt_q    <= deb_cnt_d;
            srv_cnt_q    <= srv_cnt_d;
            car_cnt_q    <= car_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        sts_w = STS_QUEUED;
        if (car_cnt_q == '0) begin
            sts_w = STS_IDLE;
        end else if (ctrd == GREEN) begin
            sts_w = STS_SERVING;
        end
    end

    assign x        = (car_cnt_q != '0);
    assign car_cnt  = car_cnt_q;
    assign sts      = sts_w;
    assign overflow = overflow_q;

endmodule
